// File: rtl/cordic_pkg.sv
// Shared constants for the vectoring CORDIC: binary-angle atan table, quadrant angles, FSM states.
// 16-bit binary angle format: 0x4000 = pi/2, full circle = 65536.
package cordic_pkg;

    localparam int ANG_W      = 16;
    localparam int ATAN_DEPTH = 10;
    // Fractional guard bits carried below the integer LSB so shift truncation does not bias X.
    localparam int GB         = 4;

    localparam logic [ANG_W-1:0] ANG_PI_2     = 16'h4000;
    localparam logic [ANG_W-1:0] ANG_NEG_PI_2 = 16'hC000;

    localparam logic [ANG_W-1:0] ATAN_TAB [ATAN_DEPTH] = '{
        16'h2000, 16'h12E4, 16'h09FB, 16'h0511, 16'h028B,
        16'h0145, 16'h00A2, 16'h0051, 16'h0028, 16'h0014
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_COMP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [ANG_W-1:0] atan_lut(input logic [3:0] idx);
        return (idx < 4'(ATAN_DEPTH)) ? ATAN_TAB[idx] : '0;
    endfunction

endpackage

// File: rtl/cordic_gain_comp.sv
// Shift-add multiply of the raw CORDIC X by 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9, truncated.
// Only built when GAIN_COMP_EN is defined.
`ifdef GAIN_COMP_EN
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int W  = 10,
    parameter int FW = W + GB
) (
    input  logic signed [FW-1:0] x,
    output logic        [W-1:0]  mag
);

    localparam int AW = FW + 10;

    logic signed [AW-1:0] xe;
    logic signed [AW-1:0] acc;
    logic                 unused_bits;

    assign xe  = AW'(x);
    // Exact X*311 before the single final truncation (311/512 ~= 1/K).
    assign acc = (xe <<< 8) + (xe <<< 6) - (xe <<< 3) - xe;
    assign mag = acc[GB+9 +: W];

    assign unused_bits = ^{acc[AW-1], acc[GB+8:0]};

endmodule
`endif

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: (x, y) -> atan2 angle and magnitude, one micro-rotation per clock.
// Define GAIN_COMP_EN to add a COMP cycle that scales the magnitude by 1/K.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int XY_SZ = 8,
    parameter int STG   = 8
) (
    input  logic                    CLK_100MHZ,
    input  logic                    RST_N,
    input  logic signed [XY_SZ-1:0] x_in,
    input  logic signed [XY_SZ-1:0] y_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic        [15:0]      angle_out,
    output logic        [XY_SZ+1:0] mag_out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int W  = XY_SZ + 2;
    localparam int FW = W + GB;
    localparam logic [3:0] LAST = 4'(STG - 1);

    state_t               st;
    logic                 zero_f;
    logic [3:0]           it;
    logic signed [FW-1:0] xr, yr;
    logic [15:0]          zr;

    logic signed [FW-1:0] xi, yi;
    logic signed [FW-1:0] x_pre, y_pre;
    logic [15:0]          z_pre;
    logic signed [FW-1:0] dx, dy;
    logic signed [FW-1:0] x_nx, y_nx;
    logic [15:0]          z_nx;

    assign in_ready  = RST_N && (st == ST_IDLE);
    assign out_valid = (st == ST_DONE);

    // W leaves headroom so negating the most negative input cannot overflow.
    assign xi = {{2{x_in[XY_SZ-1]}}, x_in, {GB{1'b0}}};
    assign yi = {{2{y_in[XY_SZ-1]}}, y_in, {GB{1'b0}}};

    always_comb begin
        x_pre = xi;
        y_pre = yi;
        z_pre = '0;
        if (xi[FW-1]) begin
            if (!yi[FW-1]) begin
                x_pre = yi;
                y_pre = -xi;
                z_pre = ANG_PI_2;
            end else begin
                x_pre = -yi;
                y_pre = xi;
                z_pre = ANG_NEG_PI_2;
            end
        end
    end

    always_comb begin
        dx = xr >>> it;
        dy = yr >>> it;
        if (!yr[FW-1]) begin
            x_nx = xr + dy;
            y_nx = yr - dx;
            z_nx = zr + atan_lut(it);
        end else begin
            x_nx = xr - dy;
            y_nx = yr + dx;
            z_nx = zr - atan_lut(it);
        end
    end

`ifdef GAIN_COMP_EN
    logic [W-1:0] comp_mag;

    cordic_gain_comp #(.W(W), .FW(FW)) u_gain_comp (
        .x   (xr),
        .mag (comp_mag)
    );
`endif

    always_ff @(posedge CLK_100MHZ) begin
        if (!RST_N) begin
            st        <= ST_IDLE;
            it        <= '0;
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            zero_f    <= 1'b0;
            angle_out <= '0;
            mag_out   <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (in_valid) begin
                        xr     <= x_pre;
                        yr     <= y_pre;
                        zr     <= z_pre;
                        it     <= '0;
                        zero_f <= (x_in == '0) && (y_in == '0);
                        st     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    xr <= x_nx;
                    yr <= y_nx;
                    zr <= z_nx;
                    it <= it + 4'd1;
                    if (it == LAST) begin
                        it <= '0;
`ifdef GAIN_COMP_EN
                        st <= ST_COMP;
`else
                        // Zero vector still spends the full latency, then reports 0/0.
                        angle_out <= zero_f ? '0 : z_nx;
                        mag_out   <= zero_f ? '0 : x_nx[FW-1:GB];
                        st        <= ST_DONE;
`endif
                    end
                end
`ifdef GAIN_COMP_EN
                ST_COMP: begin
                    angle_out <= zero_f ? '0 : zr;
                    mag_out   <= zero_f ? '0 : comp_mag;
                    st        <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    if (out_ready)
                        st <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring against a real-arithmetic atan2/|v| model.
// Honors GAIN_COMP_EN for latency and magnitude scaling.
module tb_cordic_vectoring;

    localparam int XY_SZ = 8;
    localparam int STG   = 8;
`ifdef GAIN_COMP_EN
    localparam int LAT  = STG + 1;
    localparam bit COMP = 1'b1;
`else
    localparam int LAT  = STG;
    localparam bit COMP = 1'b0;
`endif
    localparam int ANG_TOL = 96;
    localparam real MAG_TOL = 2.0;

    logic                    CLK_100MHZ = 1'b0;
    logic                    RST_N;
    logic signed [XY_SZ-1:0] x_in, y_in;
    logic                    in_valid, in_ready;
    logic [15:0]             angle_out;
    logic [XY_SZ+1:0]        mag_out;
    logic                    out_valid, out_ready;

    int checks = 0;
    int errors = 0;

    always #5 CLK_100MHZ = ~CLK_100MHZ;

    cordic_vectoring #(.XY_SZ(XY_SZ), .STG(STG)) dut (
        .CLK_100MHZ (CLK_100MHZ),
        .RST_N      (RST_N),
        .x_in       (x_in),
        .y_in       (y_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .angle_out  (angle_out),
        .mag_out    (mag_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // Ideal atan2 in binary angle units, rounded and wrapped to 16 bits.
    function automatic logic [15:0] ref_angle(input int x, input int y);
        real a;
        int  ai;
        a  = $atan2(real'(y), real'(x)) * 32768.0 / 3.14159265358979;
        ai = $rtoi((a >= 0.0) ? a + 0.5 : a - 0.5);
        return ai[15:0];
    endfunction

    // Ideal magnitude; without compensation it carries the CORDIC gain of STG stages.
    function automatic real ref_mag(input int x, input int y);
        real r, k;
        r = $sqrt(real'(x * x + y * y));
        k = 1.0;
        for (int i = 0; i < STG; i++) k = k * $sqrt(1.0 + 2.0 ** (-2.0 * i));
        return COMP ? r : r * k;
    endfunction

    function automatic int ang_dist(input logic [15:0] a, input logic [15:0] b);
        logic signed [15:0] d;
        d = a - b;
        return (d < 0) ? -int'(d) : int'(d);
    endfunction

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    task automatic pick_vec(output int x, output int y);
        do begin
            x = int'($urandom_range(0, 255)) - 128;
            y = int'($urandom_range(0, 255)) - 128;
        end while (x * x + y * y < 1600);
    endtask

    // Presents one vector, waits for out_valid; leaves the result pending (out_ready low).
    task automatic run_vec(input int x, input int y, output logic [15:0] ang,
                           output logic [XY_SZ+1:0] mag, output int lat);
        int w = 0;
        while (!in_ready && w < 100) begin
            @(posedge CLK_100MHZ); #1; w++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout in_ready stayed %b, wanted 1", in_ready);
        end
        x_in = 8'(x); y_in = 8'(y); in_valid = 1'b1;
        @(posedge CLK_100MHZ); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge CLK_100MHZ); #1; lat++;
        end
        ang = angle_out;
        mag = mag_out;
    endtask

    task automatic pop_result();
        out_ready = 1'b1;
        @(posedge CLK_100MHZ); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; y_in = '0;
        repeat (3) @(posedge CLK_100MHZ);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (angle_out !== 16'h0) begin errors++; $display("FAIL reset_angle got %h want 0000", angle_out); end
        checks++; if (mag_out !== '0) begin errors++; $display("FAIL reset_mag got %0d want 0", mag_out); end
        RST_N = 1'b1;
        @(posedge CLK_100MHZ); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        int vx[8] = '{75, 0, 0, -75, -128, 0, 127, -1};
        int vy[8] = '{0, 75, -75, 0, -128, 0, -1, -128};
        logic [15:0] ang;
        logic [XY_SZ+1:0] mag;
        int lat;
        for (int k = 0; k < 8; k++) begin
            run_vec(vx[k], vy[k], ang, mag, lat);
            checks++;
            if (lat !== LAT) begin errors++; $display("FAIL latency (%0d,%0d) got %0d want %0d", vx[k], vy[k], lat, LAT); end
            if (vx[k] == 0 && vy[k] == 0) begin
                checks++; if (ang !== 16'h0) begin errors++; $display("FAIL zero_angle got %h want 0000", ang); end
                checks++; if (mag !== '0) begin errors++; $display("FAIL zero_mag got %0d want 0", mag); end
            end else begin
                checks++;
                if (ang_dist(ang, ref_angle(vx[k], vy[k])) > ANG_TOL) begin
                    errors++; $display("FAIL dir_angle (%0d,%0d) got %h want %h+-%0d", vx[k], vy[k], ang, ref_angle(vx[k], vy[k]), ANG_TOL);
                end
                checks++;
                if (rabs(real'(mag) - ref_mag(vx[k], vy[k])) > MAG_TOL) begin
                    errors++; $display("FAIL dir_mag (%0d,%0d) got %0d want %f+-2", vx[k], vy[k], mag, ref_mag(vx[k], vy[k]));
                end
            end
            pop_result();
        end
    endtask

    task automatic test_random();
        logic [15:0] ang;
        logic [XY_SZ+1:0] mag;
        int lat, x, y;
        for (int k = 0; k < 24; k++) begin
            pick_vec(x, y);
            run_vec(x, y, ang, mag, lat);
            checks++;
            if (lat !== LAT) begin errors++; $display("FAIL rnd_latency (%0d,%0d) got %0d want %0d", x, y, lat, LAT); end
            checks++;
            if (ang_dist(ang, ref_angle(x, y)) > ANG_TOL) begin
                errors++; $display("FAIL rnd_angle (%0d,%0d) got %h want %h+-%0d", x, y, ang, ref_angle(x, y), ANG_TOL);
            end
            checks++;
            if (rabs(real'(mag) - ref_mag(x, y)) > MAG_TOL) begin
                errors++; $display("FAIL rnd_mag (%0d,%0d) got %0d want %f+-2", x, y, mag, ref_mag(x, y));
            end
            pop_result();
        end
    endtask

    task automatic test_handshake();
        logic [15:0] ang0, ang1;
        logic [XY_SZ+1:0] mag0, mag1;
        int lat;
        run_vec(60, -30, ang0, mag0, lat);
        checks++;
        if (ang_dist(ang0, ref_angle(60, -30)) > ANG_TOL) begin
            errors++; $display("FAIL hs_angle got %h want %h+-%0d", ang0, ref_angle(60, -30), ANG_TOL);
        end
        // A competing vector is offered while the result is stalled; it must be ignored.
        x_in = -8'sd50; y_in = 8'sd90; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK_100MHZ); #1;
            checks++; if (angle_out !== ang0) begin errors++; $display("FAIL hs_hold_angle c%0d got %h want %h", c, angle_out, ang0); end
            checks++; if (mag_out !== mag0) begin errors++; $display("FAIL hs_hold_mag c%0d got %0d want %0d", c, mag_out, mag0); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hs_hold_valid c%0d got %b want 1", c, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hs_hold_in_ready c%0d got %b want 0", c, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge CLK_100MHZ); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hs_release_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hs_release_in_ready got %b want 1", in_ready); end
        @(posedge CLK_100MHZ); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hs_reaccept got in_ready %b want 0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge CLK_100MHZ); #1; lat++; end
        ang1 = angle_out; mag1 = mag_out;
        checks++; if (lat !== LAT) begin errors++; $display("FAIL hs_latency got %0d want %0d", lat, LAT); end
        checks++;
        if (ang_dist(ang1, ref_angle(-50, 90)) > ANG_TOL) begin
            errors++; $display("FAIL hs_next_angle got %h want %h+-%0d", ang1, ref_angle(-50, 90), ANG_TOL);
        end
        checks++;
        if (rabs(real'(mag1) - ref_mag(-50, 90)) > MAG_TOL) begin
            errors++; $display("FAIL hs_next_mag got %0d want %f+-2", mag1, ref_mag(-50, 90));
        end
        pop_result();
    endtask

    task automatic test_reset_mid();
        logic [15:0] ang;
        logic [XY_SZ+1:0] mag;
        int lat;
        bit late = 1'b0;
        x_in = 8'sd100; y_in = 8'sd40; in_valid = 1'b1;
        @(posedge CLK_100MHZ); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge CLK_100MHZ); #1; end
        RST_N = 1'b0;
        @(posedge CLK_100MHZ); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
        checks++; if (angle_out !== 16'h0) begin errors++; $display("FAIL rstmid_angle got %h want 0000", angle_out); end
        checks++; if (mag_out !== '0) begin errors++; $display("FAIL rstmid_mag got %0d want 0", mag_out); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %b want 0", in_ready); end
        RST_N = 1'b1;
        for (int c = 0; c < STG + 4; c++) begin
            @(posedge CLK_100MHZ); #1;
            if (out_valid) late = 1'b1;
        end
        checks++; if (late !== 1'b0) begin errors++; $display("FAIL rstmid_late_result got %b want 0", late); end
        run_vec(75, 75, ang, mag, lat);
        checks++;
        if (ang_dist(ang, 16'h2000) > ANG_TOL) begin
            errors++; $display("FAIL rstmid_next_angle got %h want 2000+-%0d", ang, ANG_TOL);
        end
        checks++;
        if (rabs(real'(mag) - ref_mag(75, 75)) > MAG_TOL) begin
            errors++; $display("FAIL rstmid_next_mag got %0d want %f+-2", mag, ref_mag(75, 75));
        end
        pop_result();
    endtask

    task automatic test_back_to_back();
        int xq[$], yq[$];
        int acc_cyc[4];
        int n_acc = 0, n_done = 0, cyc = 0, nx, ny, ex, ey;
        bit took;
        pick_vec(nx, ny);
        x_in = 8'(nx); y_in = 8'(ny); in_valid = 1'b1; out_ready = 1'b1;
        while (n_done < 4 && cyc < 400) begin
            if (out_valid && xq.size() > 0) begin
                ex = xq.pop_front(); ey = yq.pop_front();
                checks++;
                if (ang_dist(angle_out, ref_angle(ex, ey)) > ANG_TOL) begin
                    errors++; $display("FAIL b2b_angle (%0d,%0d) got %h want %h+-%0d", ex, ey, angle_out, ref_angle(ex, ey), ANG_TOL);
                end
                checks++;
                if (rabs(real'(mag_out) - ref_mag(ex, ey)) > MAG_TOL) begin
                    errors++; $display("FAIL b2b_mag (%0d,%0d) got %0d want %f+-2", ex, ey, mag_out, ref_mag(ex, ey));
                end
                n_done++;
            end
            took = in_ready && in_valid;
            if (took) begin
                xq.push_back(nx); yq.push_back(ny);
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            @(posedge CLK_100MHZ); #1;
            cyc++;
            if (took) begin
                if (n_acc < 4) begin
                    pick_vec(nx, ny);
                    x_in = 8'(nx); y_in = 8'(ny);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (n_done !== 4) begin errors++; $display("FAIL b2b_timeout results got %0d want 4", n_done); end
        for (int k = 1; k < n_acc; k++) begin
            checks++;
            if (acc_cyc[k] - acc_cyc[k-1] !== LAT + 2) begin
                errors++; $display("FAIL b2b_spacing k%0d got %0d want %0d", k, acc_cyc[k] - acc_cyc[k-1], LAT + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_handshake();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
